wheel_cmd_ramp: RTL and testbench

WHEEL_CMD_RAMP -- requirements
Module: wheel_cmd_ramp

---
 rtl/wheel_cmd_ramp.sv | 114 +++++++++++
 tb/tb_wheel_cmd_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wheel_cmd_ramp.sv
// Slew-rate limiter for a signed wheel command, with a valid/ready command input,
// a command-loss watchdog and an emergency-stop override.
module wheel_cmd_ramp #(
  parameter logic [7:0]  STEP          = 8'd4,
  parameter int unsigned UPDATE_US     = 'd1000,
  parameter int unsigned TIMEOUT_TICKS = 'd250
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              one_MHz_enable,
  input  logic signed [7:0] cmd_target,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              estop,
  output logic signed [7:0] wheel_cmd,
  output logic              at_target,
  output logic              timed_out
);

  localparam int DIV_W = (UPDATE_US > 1) ? $clog2(UPDATE_US) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(UPDATE_US - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT_TICKS);
  localparam logic [WD_W-1:0]  WD_PRE     = WD_W'(TIMEOUT_TICKS - 1);
  localparam logic signed [8:0] STEP_POS  = $signed({1'b0, STEP});
  localparam logic signed [8:0] STEP_NEG  = -STEP_POS;

  typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;

  state_t              state;
  state_t              state_next;
  logic signed [7:0]   target;
  logic signed [7:0]   target_sat;
  logic signed [7:0]   ramp_next;
  logic signed [8:0]   diff;
  logic [DIV_W-1:0]    divider;
  logic [WD_W-1:0]     watchdog;
  logic                transfer;
  logic                tick;
  logic                wd_expire;

  assign transfer   = cmd_valid && cmd_ready;
  assign tick       = one_MHz_enable && (divider == DIV_LAST);
  assign wd_expire  = tick && (watchdog == WD_PRE);
  assign target_sat = (cmd_target == -8'sd128) ? -8'sd127 : cmd_target;
  assign diff       = {target[7], target} - {wheel_cmd[7], wheel_cmd};

  // Move by at most STEP per tick; snap onto the target once it is within reach.
  always_comb begin
    ramp_next = target;
    if (diff > STEP_POS) begin
      ramp_next = wheel_cmd + STEP;
    end else if (diff < STEP_NEG) begin
      ramp_next = wheel_cmd - STEP;
    end
  end

  always_comb begin
    state_next = state;
    if (estop) begin
      state_next = ESTOP;
    end else if (state == ESTOP) begin
      state_next = IDLE;
    end else if (wheel_cmd != target) begin
      state_next = RAMP;
    end else begin
      state_next = IDLE;
    end
    cmd_ready = (state != ESTOP);
    at_target = (state == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority: estop, then transfer, then watchdog expiry; the ramp always uses the old target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wheel_cmd <= '0;
      target    <= '0;
      divider   <= '0;
      watchdog  <= '0;
      timed_out <= 1'b0;
    end else if (estop) begin
      wheel_cmd <= '0;
      target    <= '0;
      divider   <= '0;
    end else begin
      if (one_MHz_enable) begin
        divider <= tick ? '0 : divider + DIV_W'(1);
      end
      if (tick && (state != ESTOP)) begin
        wheel_cmd <= ramp_next;
      end
      if (transfer) begin
        target    <= target_sat;
        watchdog  <= '0;
        timed_out <= 1'b0;
      end else if (tick && (watchdog != WD_LIMIT)) begin
        watchdog <= watchdog + WD_W'(1);
        if (wd_expire) begin
          target    <= '0;
          timed_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wheel_cmd_ramp.sv
// Scoreboard bench for wheel_cmd_ramp: expected wheel_cmd values are queued when
// a command is driven and popped after each update tick the bench generates.
module tb_wheel_cmd_ramp;

  localparam int UPDATE_US = 2;
  localparam int TIMEOUT_TICKS = 8;
  localparam int STEP_I = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              one_MHz_enable;
  logic signed [7:0] cmd_target;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              estop;
  logic signed [7:0] wheel_cmd;
  logic              at_target;
  logic              timed_out;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];
  int model_wheel = 0;

  wheel_cmd_ramp #(
    .STEP(8'd4),
    .UPDATE_US(UPDATE_US),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .one_MHz_enable(one_MHz_enable),
    .cmd_target(cmd_target),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .estop(estop),
    .wheel_cmd(wheel_cmd),
    .at_target(at_target),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int ramp_step(input int cur, input int tgt);
    if (tgt - cur > STEP_I) return cur + STEP_I;
    if (tgt - cur < -STEP_I) return cur - STEP_I;
    return tgt;
  endfunction

  // Inputs change on the falling edge; the DUT sees them on the next rising edge.
  task automatic enable_pulse(input logic with_xfer, input int val);
    one_MHz_enable = 1'b1;
    if (with_xfer) begin
      cmd_target = 8'(val);
      cmd_valid  = 1'b1;
    end
    @(negedge clk);
    one_MHz_enable = 1'b0;
    cmd_valid      = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_tick(input logic with_xfer, input int val);
    for (int i = 0; i < UPDATE_US - 1; i++) enable_pulse(1'b0, 0);
    enable_pulse(with_xfer, val);
  endtask

  task automatic transfer_cmd(input int val);
    cmd_target = 8'(val);
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_tick(input string tag);
    if (exp_q.size() == 0) check_output({tag, "_underflow"}, 0, 1);
    else check_output(tag, int'(wheel_cmd), exp_q.pop_front());
  endtask

  task automatic apply_stimulus(input int val, input int n, input logic refresh);
    int tgt;
    tgt = (val < -127) ? -127 : val;
    transfer_cmd(val);
    for (int i = 0; i < n; i++) begin
      model_wheel = ramp_step(model_wheel, tgt);
      exp_q.push_back(model_wheel);
    end
    for (int i = 0; i < n; i++) begin
      if (refresh) transfer_cmd(val);
      do_tick(1'b0, 0);
      check_tick("ramp");
      if (i < n - 1 && model_wheel != tgt) check_output("ramp_at_target", int'(at_target), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL sim_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int wheel_tab[12];
    int tout_tab[12];
    reset = 1'b0;
    estop = 1'b0;
    one_MHz_enable = 1'b0;
    cmd_valid = 1'b0;
    cmd_target = '0;
    repeat (2) @(negedge clk);
    check_output("rst_wheel", int'(wheel_cmd), 0);
    check_output("rst_ready", int'(cmd_ready), 1);
    check_output("rst_at_target", int'(at_target), 1);
    check_output("rst_timed_out", int'(timed_out), 0);
    reset = 1'b1;
    @(negedge clk);

    // Ramp up to 20 from rest.
    cmd_target = 8'sd20;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_output("s1_at_target_start", int'(at_target), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(ramp_step(i * 4, 20));
    model_wheel = 20;
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0, 0);
      check_tick("s1_ramp");
      check_output("s1_at_target", int'(at_target), (i == 4) ? 1 : 0);
    end

    // -128 saturates to -127; keep refreshing so the watchdog never fires.
    apply_stimulus(-128, 37, 1'b1);
    check_output("s2_final", int'(wheel_cmd), -127);
    check_output("s2_at_target", int'(at_target), 1);
    check_output("s2_timed_out", int'(timed_out), 0);

    // Emergency stop to zero, then ramp to 40 and stop again mid-ramp.
    estop = 1'b1;
    @(negedge clk);
    estop = 1'b0;
    @(negedge clk);
    model_wheel = 0;
    check_output("s4_pre_wheel", int'(wheel_cmd), 0);
    apply_stimulus(48, 10, 1'b1);
    check_output("s4_mid_wheel", int'(wheel_cmd), 40);
    estop = 1'b1;
    @(negedge clk);
    check_output("s4_estop_wheel", int'(wheel_cmd), 0);
    check_output("s4_estop_ready", int'(cmd_ready), 0);
    check_output("s4_estop_at_target", int'(at_target), 0);
    cmd_target = 8'sd100;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    estop = 1'b0;
    @(negedge clk);
    check_output("s4_exit_ready", int'(cmd_ready), 1);
    check_output("s4_exit_at_target", int'(at_target), 1);
    check_output("s4_exit_wheel", int'(wheel_cmd), 0);
    model_wheel = 0;
    exp_q.push_back(0);
    do_tick(1'b0, 0);
    check_tick("s4_ignored_cmd");

    // Watchdog: 8 ticks after the transfer the target drops to 0.
    wheel_tab = '{4, 8, 12, 16, 16, 16, 16, 16, 12, 8, 4, 0};
    tout_tab  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    transfer_cmd(16);
    for (int i = 0; i < 12; i++) exp_q.push_back(wheel_tab[i]);
    for (int i = 0; i < 12; i++) begin
      do_tick(1'b0, 0);
      check_tick("s3_wd_ramp");
      check_output("s3_timed_out", int'(timed_out), tout_tab[i]);
    end
    cmd_target = 8'sd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    check_output("s3_timed_out_clear", int'(timed_out), 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    model_wheel = 0;

    // Transfer coinciding with a tick takes effect one tick later.
    exp_q.push_back(0);
    exp_q.push_back(4);
    exp_q.push_back(8);
    do_tick(1'b1, 8);
    check_tick("s5_same_edge");
    do_tick(1'b0, 0);
    check_tick("s5_next");
    do_tick(1'b0, 0);
    check_tick("s5_done");
    check_output("s5_at_target", int'(at_target), 1);
    model_wheel = 8;

    // Asynchronous reset between edges mid-ramp.
    apply_stimulus(100, 3, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_output("s6_async_wheel", int'(wheel_cmd), 0);
    check_output("s6_async_at_target", int'(at_target), 1);
    check_output("s6_async_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(0);
    exp_q.push_back(0);
    do_tick(1'b0, 0);
    check_tick("s6_post_reset");
    do_tick(1'b0, 0);
    check_tick("s6_post_reset");
    check_output("s6_at_target", int'(at_target), 1);
    check_output("s6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
